// File: rtl/fifo_uart_tx.sv
// Purpose : drains a registered-read FIFO one word at a time onto an 8N1 UART TX line.
// Latency : FETCH + LOAD (2 cycles) before the start bit; frame = 2 + (DATA_W+2)*CLKS_PER_BIT cycles.
// Backpres: pops only when fifo_empty=0, sampled in IDLE and on the final stop cycle; exactly one pop per frame.
//
// Ports:
//   clk, rst (async, active-low)     clock and reset
//   fifo_empty, fifo_rd_data         FIFO status and registered read data (valid the cycle after fifo_rd_en)
//   fifo_rd_en                       one-cycle pop strobe per word
//   tx, busy, tx_done                serial line (idle 1), frame-in-progress flag, end-of-stop pulse
module fifo_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              last_cyc;

  assign last_cyc = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) state_d = S_FETCH;
      end
      S_FETCH: begin
        cnt_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // Registered-read FIFO: data popped in FETCH is valid now.
        shift_d = fifo_rd_data;
        cnt_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (last_cyc) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (last_cyc) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_MAX) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (last_cyc) begin
          cnt_d   = '0;
          // Chain straight into the next pop when more data is waiting.
          state_d = fifo_empty ? S_IDLE : S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered, so they line up
    // with state_q without any combinational path from the inputs.
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    rd_en_d = (state_d == S_FETCH);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_STOP) && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_rd_en = rd_en_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Purpose : directed self-checking bench for fifo_uart_tx (CLKS_PER_BIT=4 and =2 instances).
// Latency : expected frame timing is hand-derived: FETCH, LOAD, then 10 bits of CLKS_PER_BIT cycles.
// Backpres: simple registered-read FIFO models feed each instance; fifo_empty can be forced high.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks   = 0;
  int   failures = 0;

  // FIFO model + DUT, CLKS_PER_BIT = 4
  logic       fe4, re4, tx4, busy4, done4, force_e4;
  logic [7:0] rd4 = 8'h00;
  logic [7:0] mem4 [0:15];
  int         wp4 = 0, rp4 = 0, pops4 = 0, dones4 = 0;
  assign fe4 = force_e4 || (wp4 == rp4);
  always @(posedge clk) begin
    if (re4) begin
      rd4 <= mem4[rp4];
      rp4 <= rp4 + 1;
      pops4++;
    end
    if (done4) dones4++;
  end

  // FIFO model + DUT, CLKS_PER_BIT = 2
  logic       fe2, re2, tx2, busy2, done2, force_e2;
  logic [7:0] rd2 = 8'h00;
  logic [7:0] mem2 [0:15];
  int         wp2 = 0, rp2 = 0, pops2 = 0;
  assign fe2 = force_e2 || (wp2 == rp2);
  always @(posedge clk) begin
    if (re2) begin
      rd2 <= mem2[rp2];
      rp2 <= rp2 + 1;
      pops2++;
    end
  end

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .fifo_empty(fe4), .fifo_rd_data(rd4),
    .fifo_rd_en(re4), .tx(tx4), .busy(busy4), .tx_done(done4)
  );

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(2)) u_dut2 (
    .clk(clk), .rst(rst), .fifo_empty(fe2), .fifo_rd_data(rd2),
    .fifo_rd_en(re2), .tx(tx2), .busy(busy2), .tx_done(done2)
  );

  // Frame checker looks at whichever instance sel points to.
  logic sel;
  logic tx_s, re_s, busy_s, done_s;
  assign tx_s   = sel ? tx2   : tx4;
  assign re_s   = sel ? re2   : re4;
  assign busy_s = sel ? busy2 : busy4;
  assign done_s = sel ? done2 : done4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the pop strobe is seen.
  task automatic wait_fetch(input string tag, input int limit);
    int n = 0;
    while (re_s !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_fetch_seen"}, {31'd0, re_s}, 32'd1);
  endtask

  // Entered at the FETCH-cycle negedge; returns at the final stop-cycle negedge.
  task automatic frame(input string tag, input int cpb, input logic [7:0] exp);
    logic [9:0] bits = '0;
    logic       first = 1'b0;
    int hold_err = 0, busy_err = 0, rd_cnt = 0, done_cnt = 0, done_last = 0;
    chk({tag, "_fetch_busy"}, {31'd0, busy_s}, 32'd1);
    @(negedge clk);
    chk({tag, "_load_rden"}, {31'd0, re_s}, 32'd0);
    chk({tag, "_load_tx"},   {31'd0, tx_s}, 32'd1);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        if (c == 0) begin
          first   = tx_s;
          bits[b] = tx_s;
        end else if (tx_s !== first) begin
          hold_err++;
        end
        if (busy_s !== 1'b1) busy_err++;
        if (re_s === 1'b1) rd_cnt++;
        if (done_s === 1'b1) begin
          done_cnt++;
          if (b == 9 && c == cpb - 1) done_last = 1;
        end
      end
    end
    chk({tag, "_start_bit"}, {31'd0, bits[0]}, 32'd0);
    chk({tag, "_data"},      {24'd0, bits[8:1]}, {24'd0, exp});
    chk({tag, "_stop_bit"},  {31'd0, bits[9]}, 32'd1);
    chk({tag, "_bit_hold"},  hold_err, 0);
    chk({tag, "_busy_held"}, busy_err, 0);
    chk({tag, "_no_midpop"}, rd_cnt, 0);
    chk({tag, "_done_cnt"},  done_cnt, 1);
    chk({tag, "_done_last"}, done_last, 1);
  endtask

  initial begin
    sel      = 1'b0;
    force_e4 = 1'b1;
    force_e2 = 1'b1;
    rst      = 1'b0;

    // Reset held with a word available: outputs stay idle, nothing is popped.
    mem4[0]  = 8'hA5;
    wp4      = 1;
    force_e4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("reset_outputs", {28'd0, tx4, re4, busy4, done4}, 32'b1000);
    end
    chk("reset_no_pop", pops4, 0);
    force_e4 = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("release_idle", {28'd0, tx4, re4, busy4, done4}, 32'b1000);
    chk("release_no_pop", pops4, 0);

    // Single word 0xA5.
    force_e4 = 1'b0;
    wait_fetch("single", 10);
    frame("single", 4, 8'hA5);
    @(negedge clk);
    chk("single_idle_after", {30'd0, busy4, re4}, 32'd0);
    chk("single_pops", pops4, 1);
    chk("single_dones", dones4, 1);

    // Back-to-back frames.
    mem4[1] = 8'h00;
    mem4[2] = 8'hFF;
    mem4[3] = 8'h3C;
    wp4     = 4;
    wait_fetch("b2b0", 10);
    frame("b2b0", 4, 8'h00);
    @(negedge clk);
    chk("b2b_nogap1", {31'd0, re4}, 32'd1);
    frame("b2b1", 4, 8'hFF);
    @(negedge clk);
    chk("b2b_nogap2", {31'd0, re4}, 32'd1);
    frame("b2b2", 4, 8'h3C);
    @(negedge clk);
    chk("b2b_idle_after", {31'd0, busy4}, 32'd0);
    chk("b2b_pops", pops4, 4);
    chk("b2b_dones", dones4, 4);

    // fifo_empty toggles during DATA with a second word queued.
    mem4[4] = 8'h5A;
    mem4[5] = 8'hC3;
    wp4     = 6;
    wait_fetch("emf0", 10);
    fork
      frame("emf0", 4, 8'h5A);
      begin
        repeat (10) @(negedge clk);
        force_e4 = 1'b1;
        repeat (12) @(negedge clk);
        force_e4 = 1'b0;
      end
    join
    @(negedge clk);
    chk("emf_pop_after_stop", {31'd0, re4}, 32'd1);
    frame("emf1", 4, 8'hC3);
    @(negedge clk);
    chk("emf_idle_after", {31'd0, busy4}, 32'd0);
    chk("emf_pops", pops4, 6);

    // Reset during data bit 3 of a 0x00 frame.
    mem4[6] = 8'h00;
    wp4     = 7;
    wait_fetch("rmf", 10);
    repeat (19) @(negedge clk);
    chk("rmf_tx_before", {31'd0, tx4}, 32'd0);
    #1 rst = 1'b0;
    #1 chk("rmf_async_outputs", {28'd0, tx4, re4, busy4, done4}, 32'b1000);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("rmf_idle_after", {28'd0, tx4, re4, busy4, done4}, 32'b1000);
    chk("rmf_pops", pops4, 7);
    chk("rmf_no_done", dones4, 6);

    // Minimum baud divisor on the second instance.
    sel      = 1'b1;
    mem2[0]  = 8'h81;
    wp2      = 1;
    force_e2 = 1'b0;
    wait_fetch("minbaud", 10);
    frame("minbaud", 2, 8'h81);
    @(negedge clk);
    chk("minbaud_idle_after", {31'd0, busy_s}, 32'd0);
    chk("minbaud_pops", pops2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side drain engine for the board FIFO. It pops one word at a time whenever the FIFO is not empty and serialises each word onto a UART TX line (8N1 style: start, DATA_W data bits LSB first, one stop bit).
- It sits between the FIFO read port and the Arty7 USB-UART pin, and is the consumer end of the FIFO the wrapper writes into.

Parameters:
- DATA_W, 8: word width popped from the FIFO and number of serial data bits per frame.
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200). Legal range is 2 and above.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- fifo_empty  in  1  FIFO empty flag; 1 = no word available.
- fifo_rd_data  in  DATA_W  FIFO read data; valid on the cycle after fifo_rd_en is high (registered read).
- fifo_rd_en  out  1  FIFO pop strobe; high exactly one cycle per word.
- tx  out  1  UART serial output; idle level 1.
- busy  out  1  high from the pop cycle through the last stop-bit cycle.
- tx_done  out  1  one-cycle pulse on the final cycle of each stop bit.

Behaviour:
- Reset (rst=0, async):
  - tx=1, fifo_rd_en=0, busy=0, tx_done=0.
  - FSM goes to IDLE; baud counter and bit index go to 0; shift register goes to 0.
  - Reset mid-frame: tx returns to 1 immediately and the in-flight word is discarded. No extra pop is issued on reset release.
- All outputs are registered (driven from state/registers, no combinational path from inputs).
- FSM states and transitions:
  - IDLE: tx=1, busy=0. If fifo_empty=0, go to FETCH.
  - FETCH (1 cycle): fifo_rd_en=1, busy=1. Go to LOAD.
  - LOAD (1 cycle): capture fifo_rd_data into the shift register; fifo_rd_en=0. Go to START.
  - START: tx=0 for CLKS_PER_BIT cycles. Go to DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After DATA_W bits, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, tx_done=1. From that last cycle, go to FETCH if fifo_empty=0, else to IDLE (back-to-back frames, no idle gap).
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and is reset to 0 on every state entry.
  - Width is clog2(CLKS_PER_BIT).
  - Bit index counts 0..DATA_W-1.
- Sampling of fifo_empty:
  - fifo_empty is sampled only in IDLE and on the final STOP cycle.
  - Changes in fifo_empty during a frame are ignored.
  - Exactly one pop per frame.
- Frame length: 2 + (DATA_W+2)*CLKS_PER_BIT cycles from FETCH to the end of STOP. The two extra cycles are FETCH and LOAD.
- Throughput: with the FIFO never empty, one frame every 2 + (DATA_W+2)*CLKS_PER_BIT cycles.
- The block never pops when fifo_empty=1, so no underflow is possible.
- The block does not inspect or hold state for overflow; that is the writer's responsibility.

Test Plan:
- Reset: hold rst=0 with fifo_empty=0 -> tx=1, fifo_rd_en=0, busy=0, tx_done=0 throughout; no pop occurs.
- Single word (CLKS_PER_BIT=4, DATA_W=8): push 0xA5, then drop fifo_empty -> one fifo_rd_en pulse, then tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. tx_done pulses once, 42 cycles after FETCH begins. busy returns to 0 and the FSM returns to IDLE.
- Back-to-back: preload 0x00, 0xFF, 0x3C -> three frames with no idle cycle between the first stop bit and the next FETCH. Decoded words are 0x00, 0xFF, 0x3C in order. Exactly 3 fifo_rd_en pulses and 3 tx_done pulses.
- Empty-mid-frame: one word queued; fifo_empty rises during DATA and falls again during DATA -> no extra pop mid-frame; the next pop happens on the final STOP cycle.
- Reset mid-frame: assert rst=0 during bit 3 of DATA -> tx=1 within the same cycle (async). After release, the block stays IDLE with busy=0 while fifo_empty=1.
- Minimum baud (CLKS_PER_BIT=2): send 0x81 -> bit timing is exactly 2 cycles per bit and the decoded word is 0x81.
